neuron_mac_sequencer: RTL and testbench

Controller that sequences a weighted-sum neuron as a time-multiplexed datapath. It holds 8 activations (10-bit) and 8 weights (8-bit, 1.7 unsigned) in local register banks, loaded over a narrow write port. On start it runs a single shared multiply-accumulate across all 8 pairs, one pair per cycle. It then presents the 21-bit sum on a valid/ready output port. It sits between the chip's serial IO front end and downstream result readout, and replaces an 8-multiplier parallel neuron to save area.

---
 rtl/neuron_mac_sequencer_if.sv | 30 +++
 rtl/neuron_mac_sequencer.sv | 104 ++++++++++
 tb/tb_neuron_mac_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_sequencer_if.sv
// rtl/neuron_mac_sequencer_if.sv - bank write port, run control and result handshake bundle
interface neuron_mac_sequencer_if #(
  parameter int N_IN  = 8,
  parameter int X_W   = 10,
  parameter int W_W   = 8,
  parameter int ACC_W = 21
);
  localparam int IDX_W = $clog2(N_IN);

  logic             start_i;
  logic             wr_en_i;
  logic             wr_sel_i;
  logic [IDX_W-1:0] wr_addr_i;
  logic [X_W-1:0]   wr_data_i;
  logic             busy_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [ACC_W-1:0] result_o;
  logic             wr_err_o;

  modport slave (
    input  start_i, wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, res_ready_i,
    output busy_o, res_valid_o, result_o, wr_err_o
  );

  modport master (
    output start_i, wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, res_ready_i,
    input  busy_o, res_valid_o, result_o, wr_err_o
  );
endinterface

// File: rtl/neuron_mac_sequencer.sv
// rtl/neuron_mac_sequencer.sv - time-multiplexed weighted-sum neuron, one shared MAC over N_IN pairs
module neuron_mac_sequencer #(
  parameter int N_IN  = 8,
  parameter int X_W   = 10,
  parameter int W_W   = 8,
  parameter int ACC_W = 21
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  neuron_mac_sequencer_if.slave bus
);
  localparam int IDX_W  = $clog2(N_IN);
  localparam int PROD_W = X_W + W_W;

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] result_q;
  logic             valid_q;
  logic             wr_err_q;
  logic [X_W-1:0]   x_bank [N_IN];
  logic [W_W-1:0]   w_bank [N_IN];

  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  sum;
  logic              last_pair;

  // Single multiplier and adder, operands picked by idx; weights zero-extended.
  assign product   = {{W_W{1'b0}}, x_bank[idx_q]} * {{X_W{1'b0}}, w_bank[idx_q]};
  assign sum       = acc_q + {{(ACC_W-PROD_W){1'b0}}, product};
  assign last_pair = (idx_q == IDX_W'(N_IN-1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i)     state_d = MAC;
      MAC:     if (last_pair)       state_d = HOLD;
      HOLD:    if (bus.res_ready_i) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        x_bank[i] <= '0;
        w_bank[i] <= '0;
      end
    end else begin
      wr_err_q <= 1'b0;
      // Banks feed the live datapath during MAC, so writes there are refused.
      if (bus.wr_en_i) begin
        if (state_q == MAC) begin
          wr_err_q <= 1'b1;
        end else if (bus.wr_sel_i) begin
          x_bank[bus.wr_addr_i] <= bus.wr_data_i;
        end else begin
          w_bank[bus.wr_addr_i] <= bus.wr_data_i[W_W-1:0];
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        MAC: begin
          acc_q <= sum;
          idx_q <= idx_q + IDX_W'(1);
          if (last_pair) begin
            result_q <= sum;
            valid_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.res_ready_i) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = (state_q == MAC);
  assign bus.res_valid_o = valid_q;
  assign bus.result_o    = result_q;
  assign bus.wr_err_o    = wr_err_q;
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb/tb_neuron_mac_sequencer.sv - directed scoreboard bench for neuron_mac_sequencer
module tb_neuron_mac_sequencer;
  logic clk_i = 1'b0;
  logic rst_i;

  neuron_mac_sequencer_if bus ();

  neuron_mac_sequencer dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int mx [8];
  int mw [8];
  int exp_q [$];
  int held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += mx[i] * mw[i];
    return s;
  endfunction

  task automatic write(input bit sel, input int addr, input int data);
    bus.wr_en_i   = 1'b1;
    bus.wr_sel_i  = sel;
    bus.wr_addr_i = 3'(addr);
    bus.wr_data_i = 10'(data);
    tick();
    bus.wr_en_i = 1'b0;
    if (sel) mx[addr] = data & 10'h3FF;
    else     mw[addr] = data & 8'hFF;
  endtask

  task automatic load(input int xv [8], input int wv [8]);
    for (int i = 0; i < 8; i++) begin
      write(1'b1, i, xv[i]);
      write(1'b0, i, wv[i]);
    end
  endtask

  task automatic start_run();
    bus.start_i = 1'b1;
    exp_q.push_back(model_sum());
    tick();
    bus.start_i = 1'b0;
  endtask

  // pre = ticks already spent after the start edge before calling
  task automatic finish_run(input string tag, input int pre);
    int n = 0;
    int busy_cnt = 0;
    int exp;
    while (!bus.res_valid_o && n < 20) begin
      if (bus.busy_o) busy_cnt++;
      tick();
      n++;
    end
    check({tag, "_latency"}, n + pre, 8);
    check({tag, "_busy_cycles"}, busy_cnt + pre, 8);
    check({tag, "_busy_low_in_hold"}, bus.busy_o, 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check({tag, "_result"}, bus.result_o, exp);
  endtask

  task automatic handshake(input string tag);
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    check({tag, "_valid_cleared"}, bus.res_valid_o, 0);
  endtask

  initial begin
    int xs [8];
    int ws [8];
    bus.start_i     = 1'b0;
    bus.wr_en_i     = 1'b0;
    bus.wr_sel_i    = 1'b0;
    bus.wr_addr_i   = '0;
    bus.wr_data_i   = '0;
    bus.res_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin mx[i] = 0; mw[i] = 0; end

    rst_i = 1'b0;
    #13;
    check("rst_busy", bus.busy_o, 0);
    check("rst_valid", bus.res_valid_o, 0);
    check("rst_result", bus.result_o, 0);
    check("rst_wr_err", bus.wr_err_o, 0);
    tick();
    rst_i = 1'b1;
    tick();

    start_run();
    finish_run("zero_banks", 0);
    handshake("zero_banks");

    for (int i = 0; i < 8; i++) begin xs[i] = i + 1; ws[i] = 1; end
    load(xs, ws);
    start_run();
    finish_run("basic", 0);
    check("basic_const", bus.result_o, 36);
    handshake("basic");

    // write and start in the same IDLE cycle: new weight used by the run
    bus.wr_en_i = 1'b1; bus.wr_sel_i = 1'b0; bus.wr_addr_i = 3'd7; bus.wr_data_i = 10'h302;
    mw[7] = 2;
    start_run();
    bus.wr_en_i = 1'b0;
    finish_run("wr_with_start", 0);
    handshake("wr_with_start");

    for (int i = 0; i < 8; i++) begin xs[i] = 1023; ws[i] = 255; end
    load(xs, ws);
    start_run();
    finish_run("max", 0);
    check("max_const", bus.result_o, 2086920);
    handshake("max");

    for (int i = 0; i < 8; i++) begin xs[i] = 2; ws[i] = 3; end
    load(xs, ws);
    start_run();
    tick();
    tick();
    bus.wr_en_i = 1'b1; bus.wr_sel_i = 1'b1; bus.wr_addr_i = 3'd0; bus.wr_data_i = 10'd100;
    tick();
    bus.wr_en_i = 1'b0;
    check("mac_wr_err_pulse", bus.wr_err_o, 1);
    tick();
    check("mac_wr_err_one_cycle", bus.wr_err_o, 0);
    finish_run("mac_write", 4);
    handshake("mac_write");
    start_run();
    finish_run("after_drop", 0);
    check("after_drop_const", bus.result_o, 48);
    handshake("after_drop");

    for (int i = 0; i < 8; i++) begin xs[i] = 10 * i + 7; ws[i] = 200 - 13 * i; end
    load(xs, ws);
    start_run();
    finish_run("bp", 0);
    held = bus.result_o;
    for (int k = 0; k < 5; k++) begin
      bus.start_i = (k == 2);
      tick();
      check("bp_valid_held", bus.res_valid_o, 1);
      check("bp_result_stable", bus.result_o, model_sum());
      check("bp_not_busy", bus.busy_o, 0);
    end
    bus.start_i = 1'b1;
    handshake("bp");
    bus.start_i = 1'b0;
    tick();
    tick();
    check("bp_no_second_run_busy", bus.busy_o, 0);
    check("bp_no_second_run_valid", bus.res_valid_o, 0);
    check("bp_result_kept", bus.result_o, held);

    for (int i = 0; i < 8; i++) begin xs[i] = i + 1; ws[i] = 1; end
    load(xs, ws);
    start_run();
    tick();
    tick();
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    check("midrun_rst_busy", bus.busy_o, 0);
    check("midrun_rst_valid", bus.res_valid_o, 0);
    check("midrun_rst_result", bus.result_o, 0);
    void'(exp_q.pop_back());
    for (int i = 0; i < 8; i++) begin mx[i] = 0; mw[i] = 0; end
    tick();
    rst_i = 1'b1;
    tick();
    start_run();
    finish_run("cleared_banks", 0);
    handshake("cleared_banks");
    load(xs, ws);
    start_run();
    finish_run("reload", 0);
    check("reload_const", bus.result_o, 36);
    handshake("reload");

    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
